// File: rtl/fp_pkg.sv
// Shared widths, field helpers and stage bundles
// for the pipelined floating-point add/sub lanes.
package fp_pkg;

  localparam int EXP_BITS  = 5;
  localparam int MANT_BITS = 6;
  localparam int W    = 1 + EXP_BITS + MANT_BITS;
  localparam int MW   = MANT_BITS + 1;
  localparam int XW   = MW + 3;
  localparam int SW   = XW + 1;
  localparam int LZW  = $clog2(SW);
  localparam int EW   = EXP_BITS + 3;
  localparam int EMAX = 2**EXP_BITS - 1;

  function automatic int bias();
    return 2**(EXP_BITS-1) - 1;
  endfunction

  function automatic logic f_sign(
    input logic [W-1:0] x
  );
    return x[W-1];
  endfunction

  function automatic logic [EXP_BITS-1:0] f_exp(
    input logic [W-1:0] x
  );
    return x[W-2 -: EXP_BITS];
  endfunction

  function automatic logic [MANT_BITS-1:0] f_mant(
    input logic [W-1:0] x
  );
    return x[MANT_BITS-1:0];
  endfunction

  typedef struct packed {
    logic                sign_l;
    logic                sign_s;
    logic [EXP_BITS-1:0] exp;
    logic [XW-1:0]       mant_l;
    logic [XW-1:0]       mant_s;
  } align_t;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exp;
    logic [SW-1:0]       sum;
  } add_t;

endpackage

// File: rtl/fp_add_lane.sv
// One lane: align, add, normalise/round.
// All three registers advance together on en.
module fp_add_lane
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         ovf
);

  align_t s1_d, s1_q;
  add_t   s2_d, s2_q;
  logic [W-1:0] y_d;
  logic         ovf_d;

  logic za, zb, sa, sb, a_ge;
  logic [EXP_BITS-1:0] ea, eb, el, es, d;
  logic [MW-1:0] ma, mb, ml, ms;
  logic [XW-2:0] ext;
  logic [2*(XW-1)-1:0] full;

  always_comb begin
    za   = f_exp(a) == '0;
    zb   = f_exp(b) == '0;
    ea   = f_exp(a);
    eb   = f_exp(b);
    ma   = za ? '0 : {1'b1, f_mant(a)};
    mb   = zb ? '0 : {1'b1, f_mant(b)};
    sa   = f_sign(a);
    sb   = f_sign(b) ^ sub;
    a_ge = {ea, ma} >= {eb, mb};
    el   = a_ge ? ea : eb;
    es   = a_ge ? eb : ea;
    ml   = a_ge ? ma : mb;
    ms   = a_ge ? mb : ma;
    d    = el - es;
    ext  = {ms, 2'b00};
    full = {ext, {(XW-1){1'b0}}} >> d;
    s1_d.sign_l = a_ge ? sa : sb;
    s1_d.sign_s = a_ge ? sb : sa;
    s1_d.exp    = el;
    s1_d.mant_l = {ml, 3'b000};
    // far-apart operands collapse into the sticky bit
    if (int'(d) >= MANT_BITS + 3)
      s1_d.mant_s = {{(XW-1){1'b0}}, |ms};
    else
      s1_d.mant_s = {full[2*(XW-1)-1 -: XW-1],
                     |full[XW-2:0]};
  end

  always_comb begin
    s2_d.exp = s1_q.exp;
    if (s1_q.sign_l == s1_q.sign_s)
      s2_d.sum = {1'b0, s1_q.mant_l}
               + {1'b0, s1_q.mant_s};
    else
      s2_d.sum = {1'b0, s1_q.mant_l}
               - {1'b0, s1_q.mant_s};
    // a zero sum is negative only for (-0)+(-0)
    if (s2_d.sum == '0)
      s2_d.sign = s1_q.sign_l & s1_q.sign_s;
    else
      s2_d.sign = s1_q.sign_l;
  end

  logic [LZW-1:0] lz;
  logic lead, g, st, up;
  logic [SW-2:0] n;
  logic [MANT_BITS-1:0] mant;
  logic [MANT_BITS:0] mr;
  logic signed [EW-1:0] e_pre, e_fin;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW; i++)
      if (s2_q.sum[i]) lz = LZW'(SW - 1 - i);
    {lead, n} = s2_q.sum << lz;
    mant  = n[SW-2 -: MANT_BITS];
    g     = n[SW-2-MANT_BITS];
    st    = |n[SW-3-MANT_BITS:0];
    up    = g & (st | mant[0]);
    mr    = {1'b0, mant} + (MANT_BITS+1)'(up);
    e_pre = EW'(s2_q.exp) + EW'(1) - EW'(lz);
    e_fin = e_pre + EW'(mr[MANT_BITS]);
    y_d   = {s2_q.sign, {(W-1){1'b0}}};
    ovf_d = 1'b0;
    if (!lead || e_pre[EW-1] || e_pre == '0) begin
      y_d = {s2_q.sign, {(W-1){1'b0}}};
    end else if ($unsigned(e_fin) > EW'(EMAX)) begin
      y_d   = {s2_q.sign, {(W-1){1'b1}}};
      ovf_d = 1'b1;
    end else begin
      y_d = {s2_q.sign, e_fin[EXP_BITS-1:0],
             mr[MANT_BITS-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      y    <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      y    <= y_d;
      ovf  <= ovf_d;
    end
  end

endmodule

// File: rtl/fp_vector_addsub.sv
// LANES-wide 3-stage FP add/sub with valid/ready.
// Stages never collapse bubbles; en stalls all.
module fp_vector_addsub
  import fp_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sub,
  input  logic [LANES*W-1:0] a_vec,
  input  logic [LANES*W-1:0] b_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_vec,
  output logic [LANES-1:0]   out_ovf
);

  logic en, v1, v2;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_add_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a_vec[i*W +: W]),
      .b   (b_vec[i*W +: W]),
      .sub (in_sub),
      .y   (out_vec[i*W +: W]),
      .ovf (out_ovf[i])
    );
  end

endmodule

// File: tb/tb_fp_vector_addsub.sv
// Directed bench: rotated lane table, latency,
// backpressure and mid-stream reset sequences.
module tb_fp_vector_addsub;
  import fp_pkg::*;

  localparam int L  = 4;
  localparam int LW = L * W;
  localparam int NT = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         ovf;
  } vec_t;

  logic clk = 0;
  logic rst, in_valid, in_ready, in_sub;
  logic out_valid, out_ready;
  logic [LW-1:0] a_vec, b_vec, out_vec;
  logic [L-1:0]  out_ovf;

  fp_vector_addsub #(.LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  vec_t tbl [NT];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [LW-1:0] cur_vec;
  logic [L-1:0]  cur_ovf;
  logic [LW-1:0] q_vec [$];
  logic [L-1:0]  q_ovf [$];
  logic          prev_stall = 0;
  logic [LW-1:0] prev_vec;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q_vec.delete();
      q_ovf.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_vec", 64'(out_vec),
            64'(prev_vec));
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (q_vec.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none",
                   out_vec);
        end else begin
          chk("out_vec", 64'(out_vec),
              64'(q_vec.pop_front()));
          chk("out_ovf", 64'(out_ovf),
              64'(q_ovf.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        q_vec.push_back(cur_vec);
        q_ovf.push_back(cur_ovf);
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vec;
    end
  end

  task automatic send_rot(input int k, input logic s);
    logic [W-1:0] bb;
    int idx;
    bit done;
    for (int j = 0; j < L; j++) begin
      idx = (k + j) % NT;
      bb  = tbl[idx].b;
      if (s) bb[W-1] = ~bb[W-1];
      a_vec[j*W +: W]   = tbl[idx].a;
      b_vec[j*W +: W]   = bb;
      cur_vec[j*W +: W] = tbl[idx].y;
      cur_ovf[j]        = tbl[idx].ovf;
    end
    in_sub   = s;
    in_valid = 1;
    done     = 0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready expected accept");
    end
  endtask

  initial begin
    tbl[0]  = '{12'b0_10000_100100, 12'b0_01111_110100, 12'b0_10001_001111, 0};
    tbl[1]  = '{12'b0_10000_100100, 12'b1_10000_100100, 12'b0_00000_000000, 0};
    tbl[2]  = '{12'b0_01111_000000, 12'b1_01111_000000, 12'b0_00000_000000, 0};
    tbl[3]  = '{12'b0_01111_000000, 12'b0_01000_000000, 12'b0_01111_000000, 0};
    tbl[4]  = '{12'b0_01111_000001, 12'b0_01000_000000, 12'b0_01111_000010, 0};
    tbl[5]  = '{12'b0_11111_111111, 12'b0_11111_111111, 12'b0_11111_111111, 1};
    tbl[6]  = '{12'b1_11111_111111, 12'b1_11111_111111, 12'b1_11111_111111, 1};
    tbl[7]  = '{12'b0_00000_000101, 12'b0_01111_000000, 12'b0_01111_000000, 0};
    tbl[8]  = '{12'b1_00000_000000, 12'b1_00000_000000, 12'b1_00000_000000, 0};
    tbl[9]  = '{12'b0_10000_100100, 12'b1_01111_110100, 12'b0_01111_010100, 0};
    tbl[10] = '{12'b1_01111_110100, 12'b0_10000_100100, 12'b0_01111_010100, 0};
    tbl[11] = '{12'b0_01111_000001, 12'b0_01000_100000, 12'b0_01111_000010, 0};
    tbl[12] = '{12'b0_01111_111111, 12'b0_01000_100000, 12'b0_10000_000000, 0};
    tbl[13] = '{12'b0_11111_111111, 12'b0_11000_100000, 12'b0_11111_111111, 1};
    tbl[14] = '{12'b0_00001_000001, 12'b1_00001_000000, 12'b0_00000_000000, 0};
    tbl[15] = '{12'b0_10000_000000, 12'b1_00111_000000, 12'b0_10000_000000, 0};

    rst = 1; in_valid = 0; in_sub = 0; out_ready = 1;
    a_vec = '0; b_vec = '0; cur_vec = '0; cur_ovf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vec", 64'(out_vec), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 0;
    @(posedge clk);
    #1;

    send_rot(0, 0);
    @(posedge clk); #1;
    chk("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_due", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < NT; k++)
      send_rot(k, 1'(k & 1));
    repeat (6) @(posedge clk);
    #1;

    fork
      begin
        for (int k = 0; k < 8; k++)
          send_rot(k + 3, 1'((k >> 1) & 1));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    out_ready = 0;
    for (int k = 0; k < 3; k++)
      send_rot(k + 5, 0);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_vec", 64'(out_vec), 64'd0);
    chk("midrst_ovf", 64'(out_ovf), 64'd0);
    rst = 0;
    out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_quiet", 64'(out_valid), 64'd0);
    send_rot(9, 1);
    @(posedge clk); #1;
    chk("postrst_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("postrst_due", 64'(out_valid), 64'd1);

    for (int t = 0; t < 100 && q_vec.size() != 0; t++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain", 64'(q_vec.size()), 64'd0);
    chk("delivered", 64'(n_out), 64'd26);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
